// File: rtl/mem_stall_ctrl.sv
// MEM-stage access sequencer for a variable-latency data memory (req/ack handshake).
// It freezes the upstream pipeline while an access is outstanding and flags a sticky error on timeout.
module mem_stall_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TO_CYC = 255,
  parameter int TO_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              memwb_bubble_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                err_q, err_d;
  logic                acc_s;
  logic                timeout_s;
  logic                stall_s;

  assign acc_s     = memread_i | memwrite_i;
  // Ack in the last allowed BUSY cycle wins over the timeout.
  assign timeout_s = (state_q == BUSY) && !mem_ack_i && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = acc_s ? BUSY : IDLE;
      BUSY:    state_d = (mem_ack_i || timeout_s) ? DONE : BUSY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the same cycle the access is seen; reset forces it low.
  always_comb begin
    stall_s = 1'b0;
    if (!start_i) begin
      stall_s = 1'b0;
    end else begin
      case (state_q)
        IDLE:    stall_s = acc_s;
        BUSY:    stall_s = 1'b1;
        DONE:    stall_s = 1'b0;
        default: stall_s = 1'b0;
      endcase
    end
  end

  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (acc_s) begin
          mem_req_d   = 1'b1;
          mem_we_d    = memwrite_i;
          mem_addr_d  = addr_i;
          mem_wdata_d = wdata_i;
          to_cnt_d    = {TO_W{1'b0}};
        end else begin
          mem_req_d   = 1'b0;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_s) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = {DATA_W{1'b0}};
        end else begin
          to_cnt_d  = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end
      end
      DONE:    mem_req_d = 1'b0;
      default: mem_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
      to_cnt_q    <= {TO_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
    end
  end

  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign rdata_o        = rdata_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign err_o          = err_q;
  assign stall_o        = stall_s;
  assign memwb_bubble_o = stall_s;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench for mem_stall_ctrl: per-access expectations go into a scoreboard queue and are
// checked when the access reaches its DONE cycle.
module tb_mem_stall_ctrl;

  localparam int TO_CYC = 4;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic        memread_i, memwrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, memwb_bubble_o;
  logic [31:0] rdata_o;
  logic [15:0] stall_cnt_o;
  logic        err_o;

  mem_stall_ctrl #(.ADDR_W(32), .DATA_W(32), .TO_CYC(TO_CYC), .TO_W(8), .CNT_W(16)) dut (
    .clk_i(clk_i), .start_i(start_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .memwb_bubble_o(memwb_bubble_o),
    .rdata_o(rdata_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          req_cnt = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        exp_err = 1'b0;
  int          exp_cnt = 0;

  always @(posedge mem_req_o) req_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ack_at = BUSY cycle carrying the ack (0 = never, forcing a timeout). Caller starts just after a rising edge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rv, input int ack_at);
    exp_t e;
    int   stalls;
    int   busy;
    e.we = wr;
    if (ack_at == 0) begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.stall = 1 + TO_CYC;
    end else begin
      e.rdata = wr ? last_rdata : rv;
      e.err   = exp_err;
      e.stall = 1 + ack_at;
    end
    last_rdata = e.rdata;
    exp_err    = e.err;
    exp_q.push_back(e);

    memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd; mem_rdata_i = rv;
    #4;
    chk("idle_stall", {63'd0, stall_o}, 64'd1);
    chk("idle_bubble", {63'd0, memwb_bubble_o}, 64'd1);
    stalls = 0;
    busy   = 0;
    while (stall_o === 1'b1 && stalls < 300) begin
      stalls++;
      @(posedge clk_i); #1;
      busy++;
      mem_ack_i = (busy == ack_at) ? 1'b1 : 1'b0;
      #4;
      if (stall_o === 1'b1) begin
        chk("busy_req", {63'd0, mem_req_o}, 64'd1);
        chk("busy_we", {63'd0, mem_we_o}, {63'd0, wr});
        chk("busy_addr", {32'd0, mem_addr_o}, {32'd0, a});
        chk("busy_wdata", {32'd0, mem_wdata_o}, {32'd0, wd});
      end
    end
    e = exp_q.pop_front();
    exp_cnt += e.stall;
    chk("stall_len", 64'(stalls), 64'(e.stall));
    chk("done_rdata", {32'd0, rdata_o}, {32'd0, e.rdata});
    chk("done_req", {63'd0, mem_req_o}, 64'd0);
    chk("done_bubble", {63'd0, memwb_bubble_o}, 64'd0);
    chk("done_we", {63'd0, mem_we_o}, {63'd0, e.we});
    chk("done_err", {63'd0, err_o}, {63'd0, e.err});
    chk("done_cnt", {48'd0, stall_cnt_o}, 64'(exp_cnt));
    @(posedge clk_i); #1;
  endtask

  task automatic go_idle();
    memread_i = 1'b0; memwrite_i = 1'b0;
    #4;
    chk("idle_nostall", {63'd0, stall_o}, 64'd0);
    @(posedge clk_i); #1;
    chk("idle_noreq", {63'd0, mem_req_o}, 64'd0);
  endtask

  initial begin
    int req_before;
    start_i = 1'b0; memread_i = 1'b1; memwrite_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    #13;
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_bubble", {63'd0, memwb_bubble_o}, 64'd0);
    chk("rst_req", {63'd0, mem_req_o}, 64'd0);
    chk("rst_rdata", {32'd0, rdata_o}, 64'd0);
    chk("rst_cnt", {48'd0, stall_cnt_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    memread_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;

    access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    go_idle();
    access(1'b0, 1'b1, 32'h20, 32'h55, 32'h11111111, 1);
    go_idle();
    access(1'b1, 1'b1, 32'h30, 32'h66, 32'h22222222, 2);
    go_idle();

    req_before = req_cnt;
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE0001, 1);
    access(1'b1, 1'b0, 32'h44, 32'h0, 32'hCAFE0002, 1);
    chk("b2b_reqs", 64'(req_cnt - req_before), 64'd2);
    go_idle();

    access(1'b1, 1'b0, 32'h80, 32'h0, 32'h0BADF00D, 0);
    memread_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234;
    #4;
    chk("late_ack_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    #4;
    chk("late_ack_rdata", {32'd0, rdata_o}, 64'd0);
    chk("late_ack_req", {63'd0, mem_req_o}, 64'd0);
    chk("err_sticky", {63'd0, err_o}, 64'd1);
    @(posedge clk_i); #1;

    memread_i = 1'b1; addr_i = 32'h90;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("pre_rst_req", {63'd0, mem_req_o}, 64'd1);
    start_i = 1'b0;
    #1;
    chk("mid_rst_req", {63'd0, mem_req_o}, 64'd0);
    chk("mid_rst_stall", {63'd0, stall_o}, 64'd0);
    chk("mid_rst_addr", {32'd0, mem_addr_o}, 64'd0);
    chk("mid_rst_err", {63'd0, err_o}, 64'd0);
    chk("mid_rst_cnt", {48'd0, stall_cnt_o}, 64'd0);
    mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b1; memread_i = 1'b0;
    #4;
    mem_ack_i = 1'b0;
    chk("post_rst_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk_i); #1;
    chk("post_rst_req", {63'd0, mem_req_o}, 64'd0);
    last_rdata = 32'h0; exp_err = 1'b0; exp_cnt = 0;
    access(1'b1, 1'b0, 32'h44, 32'h0, 32'hA5A5A5A5, 1);
    go_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
